// File: rtl/food_level_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : food_level_scheduler
// Description : Owns the pet's 2-bit food level. Decays it on a seconds
//               timebase while idle, refills it while feeding, and arbitrates
//               the food/medicine buttons into one-shot, mutually exclusive
//               grants.
// Option      : ACCEL_TIME_EN - when defined, the seconds prescaler runs
//               1000x faster (terminal count CLK_HZ/1000).
// Revision    : 1.0 - initial release
// ============================================================================
module food_level_scheduler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DECAY_SEC  = 10,
  parameter int FEED_SEC   = 2,
  parameter int MED_SEC    = 3,
  parameter int LEVEL_INIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_food,
  input  logic       btn_med,
  input  logic       food_enable,
  input  logic       med_enable,
  output logic [1:0] nivel_comida,
  output logic       food_grant,
  output logic       med_grant,
  output logic       feeding,
  output logic       medicating,
  output logic       sec_tick
);

`ifdef ACCEL_TIME_EN
  localparam int c_term_raw = CLK_HZ / 1000;
`else
  localparam int c_term_raw = CLK_HZ;
`endif
  // Guard against a zero terminal count when accelerating a tiny CLK_HZ.
  localparam int c_term    = (c_term_raw < 1) ? 1 : c_term_raw;
  localparam int c_presc_w = (c_term > 1) ? $clog2(c_term) : 1;
  localparam int c_dec_w   = (DECAY_SEC > 1) ? $clog2(DECAY_SEC) : 1;
  localparam int c_feed_w  = (FEED_SEC > 1) ? $clog2(FEED_SEC) : 1;
  localparam int c_med_w   = (MED_SEC > 1) ? $clog2(MED_SEC) : 1;

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_term - 1);
  localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
  localparam logic [c_dec_w-1:0]   c_dec_last   = c_dec_w'(DECAY_SEC - 1);
  localparam logic [c_dec_w-1:0]   c_dec_one    = c_dec_w'(1);
  localparam logic [c_feed_w-1:0]  c_feed_last  = c_feed_w'(FEED_SEC - 1);
  localparam logic [c_feed_w-1:0]  c_feed_one   = c_feed_w'(1);
  localparam logic [c_med_w-1:0]   c_med_last   = c_med_w'(MED_SEC - 1);
  localparam logic [c_med_w-1:0]   c_med_one    = c_med_w'(1);
  localparam logic [1:0]           c_level_init = (LEVEL_INIT > 3) ? 2'd3 : 2'(LEVEL_INIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_MED  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [c_presc_w-1:0]  presc_q;
  logic [2:0]            food_sync_q;   // [0] first stage, [1] synchronized, [2] edge history
  logic [2:0]            med_sync_q;
  logic [1:0]            level_q, level_d;
  logic [c_dec_w-1:0]    decay_cnt_q, decay_cnt_d;
  logic [c_feed_w-1:0]   feed_cnt_q, feed_cnt_d;
  logic [c_med_w-1:0]    med_cnt_q, med_cnt_d;
  logic                  rr_q, rr_d;
  logic                  food_grant_q, food_grant_d;
  logic                  med_grant_q, med_grant_d;

  logic w_tick;
  logic w_food_req;
  logic w_med_req;
  logic w_grant_food;
  logic w_grant_med;

  // Free-running seconds prescaler; the tick is the cycle before the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (presc_q == c_presc_last) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + c_presc_one;
    end
  end

  assign w_tick = (presc_q == c_presc_last);

  // Two-flop synchronizers plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      food_sync_q <= 3'b000;
      med_sync_q  <= 3'b000;
    end else begin
      food_sync_q <= {food_sync_q[1:0], btn_food};
      med_sync_q  <= {med_sync_q[1:0], btn_med};
    end
  end

  assign w_food_req = food_sync_q[1] & ~food_sync_q[2] & food_enable;
  assign w_med_req  = med_sync_q[1]  & ~med_sync_q[2]  & med_enable;

  // Round-robin pick between simultaneous requests; only honoured in idle.
  always_comb begin
    w_grant_food = (state_q == S_IDLE) && w_food_req && (!w_med_req || !rr_q);
    w_grant_med  = (state_q == S_IDLE) && w_med_req  && (!w_food_req || rr_q);
  end

  // State, level, counters and grant pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      level_q      <= c_level_init;
      decay_cnt_q  <= '0;
      feed_cnt_q   <= '0;
      med_cnt_q    <= '0;
      rr_q         <= 1'b0;
      food_grant_q <= 1'b0;
      med_grant_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      decay_cnt_q  <= decay_cnt_d;
      feed_cnt_q   <= feed_cnt_d;
      med_cnt_q    <= med_cnt_d;
      rr_q         <= rr_d;
      food_grant_q <= food_grant_d;
      med_grant_q  <= med_grant_d;
    end
  end

  // Next-state: idle decay and arbitration, feeding refill, timed medicine.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    decay_cnt_d  = decay_cnt_q;
    feed_cnt_d   = feed_cnt_q;
    med_cnt_d    = med_cnt_q;
    rr_d         = rr_q;
    food_grant_d = 1'b0;
    med_grant_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_tick) begin
          if (decay_cnt_q == c_dec_last) begin
            decay_cnt_d = '0;
            if (level_q != 2'd0) begin
              level_d = level_q - 2'd1;
            end
          end else begin
            decay_cnt_d = decay_cnt_q + c_dec_one;
          end
        end
        if (w_food_req && w_med_req) begin
          rr_d = ~rr_q;
        end
        // A session start restarts the decay window even if a tick landed now.
        if (w_grant_food) begin
          state_d      = S_FEED;
          food_grant_d = 1'b1;
          feed_cnt_d   = '0;
          decay_cnt_d  = '0;
        end else if (w_grant_med) begin
          state_d     = S_MED;
          med_grant_d = 1'b1;
          med_cnt_d   = '0;
          decay_cnt_d = '0;
        end
      end

      S_FEED: begin
        if (w_tick) begin
          if (feed_cnt_q == c_feed_last) begin
            feed_cnt_d = '0;
            if (level_q != 2'd3) begin
              level_d = level_q + 2'd1;
            end
          end else begin
            feed_cnt_d = feed_cnt_q + c_feed_one;
          end
        end
        // Releasing the button loses any partial second of feeding.
        if (!food_sync_q[1] || !food_enable) begin
          state_d    = S_IDLE;
          feed_cnt_d = '0;
        end
      end

      S_MED: begin
        if (w_tick) begin
          if (med_cnt_q == c_med_last) begin
            state_d     = S_IDLE;
            med_cnt_d   = '0;
            decay_cnt_d = '0;
          end else begin
            med_cnt_d = med_cnt_q + c_med_one;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign nivel_comida = level_q;
  assign food_grant   = food_grant_q;
  assign med_grant    = med_grant_q;
  assign feeding      = (state_q == S_FEED);
  assign medicating   = (state_q == S_MED);
  assign sec_tick     = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_food_level_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for food_level_scheduler: directed scenarios with literal expectations,
// then randomized button/enable/reset activity, all checked each cycle against
// a behavioural model of the food-level rules.
module tb_food_level_scheduler;
  localparam int CLK_HZ     = 10;
  localparam int DECAY_SEC  = 3;
  localparam int FEED_SEC   = 2;
  localparam int MED_SEC    = 2;
  localparam int LEVEL_INIT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_food = 1'b0;
  logic       btn_med = 1'b0;
  logic       food_enable = 1'b1;
  logic       med_enable = 1'b1;
  logic [1:0] nivel_comida;
  logic       food_grant;
  logic       med_grant;
  logic       feeding;
  logic       medicating;
  logic       sec_tick;

  always #5 clk = ~clk;

  food_level_scheduler #(
    .CLK_HZ(CLK_HZ), .DECAY_SEC(DECAY_SEC), .FEED_SEC(FEED_SEC),
    .MED_SEC(MED_SEC), .LEVEL_INIT(LEVEL_INIT)
  ) dut (
    .clk(clk), .reset(reset), .btn_food(btn_food), .btn_med(btn_med),
    .food_enable(food_enable), .med_enable(med_enable),
    .nivel_comida(nivel_comida), .food_grant(food_grant), .med_grant(med_grant),
    .feeding(feeding), .medicating(medicating), .sec_tick(sec_tick)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;
  int fg_count = 0;
  int mg_count = 0;

  // Model: session kind 0=idle 1=feed 2=med; seconds counted per session.
  int m_level, m_state, m_idle_s, m_feed_s, m_med_s, m_rr, m_cyc;
  bit m_fg, m_mg;
  bit hf[3];   // raw btn_food sampled at the last three edges, [0] newest
  bit hm[3];

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_level = LEVEL_INIT; m_state = 0; m_idle_s = 0; m_feed_s = 0; m_med_s = 0;
    m_rr = 0; m_cyc = 0; m_fg = 0; m_mg = 0;
    for (int k = 0; k < 3; k++) begin hf[k] = 0; hm[k] = 0; end
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  function automatic void model_step();
    bit tick, fr, mr, held;
    int grant;
    if (!reset) return;
    tick = ((m_cyc % CLK_HZ) == CLK_HZ - 1);
    // A request is a press first seen by the synchronizer two edges ago.
    fr = hf[1] && !hf[2] && food_enable;
    mr = hm[1] && !hm[2] && med_enable;
    held = hf[1];
    m_fg = 0; m_mg = 0;
    if (m_state == 0) begin
      if (tick) begin
        m_idle_s++;
        if (m_idle_s == DECAY_SEC) begin
          m_idle_s = 0;
          if (m_level > 0) m_level--;
        end
      end
      grant = 0;
      if (fr && mr) begin grant = (m_rr == 0) ? 1 : 2; m_rr = 1 - m_rr; end
      else if (fr) grant = 1;
      else if (mr) grant = 2;
      if (grant == 1) begin m_fg = 1; m_state = 1; m_feed_s = 0; m_idle_s = 0; end
      if (grant == 2) begin m_mg = 1; m_state = 2; m_med_s = 0; m_idle_s = 0; end
    end else if (m_state == 1) begin
      if (tick) begin
        m_feed_s++;
        if (m_feed_s == FEED_SEC) begin
          m_feed_s = 0;
          if (m_level < 3) m_level++;
        end
      end
      if (!held || !food_enable) begin m_state = 0; m_feed_s = 0; end
    end else begin
      if (tick) begin
        m_med_s++;
        if (m_med_s == MED_SEC) begin m_state = 0; m_med_s = 0; m_idle_s = 0; end
      end
    end
    m_cyc++;
    hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = btn_food;
    hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = btn_med;
  endfunction

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", int'(nivel_comida), m_level);
      check("food_grant", int'(food_grant), int'(m_fg));
      check("med_grant", int'(med_grant), int'(m_mg));
      check("feeding", int'(feeding), int'(m_state == 1));
      check("medicating", int'(medicating), int'(m_state == 2));
      check("sec_tick", int'(sec_tick), int'(reset && ((m_cyc % CLK_HZ) == CLK_HZ - 1)));
    end
  end

  // Grant pulse counters used by the directed drop/gating checks.
  always @(negedge clk) begin
    if (food_grant) fg_count <= fg_count + 1;
    if (med_grant)  mg_count <= mg_count + 1;
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    model_reset();
    cyc(n);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int fg_snap, mg_snap;
    model_reset();
    chk_en = 1'b1;
    cyc(2);
    check("reset_level", int'(nivel_comida), 3);
    check("reset_feeding", int'(feeding), 0);
    reset = 1'b1;

    // Idle decay: first tick on cycle 10, level steps at edges 30/60/90.
    cyc(8);
    check("tick_early", int'(sec_tick), 0);
    cyc(1);
    check("tick_first", int'(sec_tick), 1);
    cyc(20); check("decay_29", int'(nivel_comida), 3);
    cyc(1);  check("decay_30", int'(nivel_comida), 2);
    cyc(30); check("decay_60", int'(nivel_comida), 1);
    cyc(30); check("decay_90", int'(nivel_comida), 0);
    cyc(5);  check("decay_hold0", int'(nivel_comida), 0);

    // Feed from level 0 for 45 cycles.
    btn_food = 1'b1; food_enable = 1'b1;
    cyc(2); check("feed_pre_grant", int'(food_grant), 0);
    cyc(1); check("feed_grant", int'(food_grant), 1);
    check("feed_state", int'(feeding), 1);
    cyc(1); check("feed_grant_once", int'(food_grant), 0);
    cyc(41); check("feed_level", int'(nivel_comida), 2);
    btn_food = 1'b0;
    cyc(2); check("feed_hold_after_rel", int'(feeding), 1);
    cyc(1); check("feed_exit", int'(feeding), 0);
    check("feed_level_kept", int'(nivel_comida), 2);

    // Saturation at 3 while feeding for 7 s.
    do_reset(2);
    btn_food = 1'b1;
    cyc(70);
    check("sat_level", int'(nivel_comida), 3);
    check("sat_feeding", int'(feeding), 1);
    btn_food = 1'b0;
    cyc(5);

    // Simultaneous presses: food first, then medicine.
    do_reset(2);
    btn_food = 1'b1; btn_med = 1'b1;
    cyc(3);
    check("conf1_food", int'(food_grant), 1);
    check("conf1_med", int'(med_grant), 0);
    btn_food = 1'b0; btn_med = 1'b0;
    cyc(5);
    btn_food = 1'b1; btn_med = 1'b1;
    cyc(3);
    check("conf2_food", int'(food_grant), 0);
    check("conf2_med", int'(med_grant), 1);
    check("conf2_medicating", int'(medicating), 1);
    btn_food = 1'b0; btn_med = 1'b0;
    cyc(25);
    check("med_done", int'(medicating), 0);

    // Gated press yields nothing, and no late grant when enable returns.
    food_enable = 1'b0; btn_food = 1'b1; fg_snap = fg_count;
    cyc(6); check("gated_no_grant", fg_count, fg_snap);
    food_enable = 1'b1;
    cyc(6); check("gated_no_late", fg_count, fg_snap);
    btn_food = 1'b0;
    cyc(3);

    // Medicine press during feeding is dropped.
    btn_food = 1'b1;
    cyc(4); check("drop_feeding", int'(feeding), 1);
    mg_snap = mg_count; btn_med = 1'b1;
    cyc(6);
    check("drop_no_med", mg_count, mg_snap);
    check("drop_not_med", int'(medicating), 0);
    btn_med = 1'b0;

    // Asynchronous reset in the middle of a feed session.
    reset = 1'b0; btn_food = 1'b0; model_reset();
    #1;
    check("rst_level", int'(nivel_comida), LEVEL_INIT);
    check("rst_feeding", int'(feeding), 0);
    check("rst_tick", int'(sec_tick), 0);
    cyc(2);
    reset = 1'b1; fg_snap = fg_count;
    cyc(8);
    check("rst_no_grant", fg_count, fg_snap);

    // Randomized activity against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      if ($urandom_range(0, 11) == 0) btn_food = ~btn_food;
      if ($urandom_range(0, 11) == 0) btn_med = ~btn_med;
      if ($urandom_range(0, 59) == 0 && !btn_food && !btn_med) begin
        btn_food = 1'b1; btn_med = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) food_enable = ~food_enable;
      if ($urandom_range(0, 29) == 0) med_enable = ~med_enable;
      cyc(1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
